// File: rtl/pattern_checker.sv
// Incrementing-sequence checker: locks onto a word stream, then flags and counts out-of-sequence words.
// Optional macro PATTERN_CHECKER_SATURATE_EN makes err_count saturate instead of wrapping.
module pattern_checker #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    S_UNLOCKED,
    S_LOCKING,
    S_LOCKED
  } state_t;

  state_t             state, state_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [MISS_W-1:0]  miss, miss_n;
  logic [WIDTH-1:0]   expected_n;
  logic               locked_n;
  logic               pulse_n;
  logic [ERR_W-1:0]   count_n;
  logic               match;
  logic               count_inc;

  assign match = (in_data == expected);

  always_comb begin
    state_n    = state;
    run_n      = run;
    miss_n     = miss;
    expected_n = expected;
    locked_n   = locked;
    pulse_n    = 1'b0;
    count_inc  = 1'b0;

    if (in_valid) begin
      case (state)
        S_UNLOCKED: begin
          expected_n = in_data + WIDTH'(1);
          run_n      = RUN_W'(1);
          state_n    = S_LOCKING;
        end

        S_LOCKING: begin
          expected_n = in_data + WIDTH'(1);
          if (match) begin
            run_n = run + RUN_W'(1);
            if (run == RUN_W'(LOCK_CNT - 1)) begin
              state_n  = S_LOCKED;
              locked_n = 1'b1;
              miss_n   = '0;
            end
          end else begin
            run_n = RUN_W'(1);
          end
        end

        S_LOCKED: begin
          // Expectation free-runs while locked; mismatches never resync it.
          expected_n = expected + WIDTH'(1);
          if (match) begin
            miss_n = '0;
          end else begin
            pulse_n   = 1'b1;
            count_inc = 1'b1;
            if (miss == MISS_W'(LOSS_CNT - 1)) begin
              state_n  = S_UNLOCKED;
              locked_n = 1'b0;
              miss_n   = '0;
              run_n    = '0;
            end else begin
              miss_n = miss + MISS_W'(1);
            end
          end
        end

        default: begin
          state_n  = S_UNLOCKED;
          locked_n = 1'b0;
          run_n    = '0;
          miss_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    count_n = err_count;
    if (clear) begin
      count_n = '0;
    end else if (count_inc) begin
`ifdef PATTERN_CHECKER_SATURATE_EN
      if (err_count != '1)
        count_n = err_count + ERR_W'(1);
`else
      count_n = err_count + ERR_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_UNLOCKED;
      run       <= '0;
      miss      <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      miss      <= miss_n;
      expected  <= expected_n;
      locked    <= locked_n;
      err_pulse <= pulse_n;
      err_count <= count_n;
    end
  end

endmodule

// File: tb/tb_pattern_checker.sv
// Bench for pattern_checker: a default-parameter instance and a narrow (WIDTH=8, ERR_W=2) instance
// share one stimulus stream and are compared each cycle against a rule-level reference model.
module tb_pattern_checker;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        clear;
  logic [31:0] data_a;
  logic [7:0]  data_b;

  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] count_a;
  logic [1:0]  count_b;
  logic [31:0] exp_a;
  logic [7:0]  exp_b;

  pattern_checker u_dut_a (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(data_a), .clear(clear),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(count_a), .expected(exp_a)
  );

  pattern_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) u_dut_b (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(data_b), .clear(clear),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(count_b), .expected(exp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state, index 0 = default instance, 1 = narrow instance.
  int unsigned     p_width [2] = '{32, 8};
  int unsigned     p_errw  [2] = '{16, 2};
  int unsigned     p_lock  = 4;
  int unsigned     p_loss  = 3;
  bit              m_locked[2];
  bit              m_pulse [2];
  int unsigned     m_run   [2];
  int unsigned     m_miss  [2];
  longint unsigned m_exp   [2];
  longint unsigned m_cnt   [2];

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic longint unsigned mask(input int unsigned bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
      m_miss[i] = 0;   m_exp[i] = 0;   m_cnt[i] = 0;
    end
  endtask

  // A word starts a new run unless it continues the current one; once locked, the
  // expectation just counts up and every miss is an error.
  task automatic model_step(input int i, input bit v, input longint unsigned d_in, input bit c);
    longint unsigned d;
    longint unsigned dm;
    longint unsigned cm;
    bit inc;
    dm = mask(p_width[i]);
    cm = mask(p_errw[i]);
    d = d_in & dm;
    inc = 0;
    m_pulse[i] = 0;
    if (v) begin
      if (!m_locked[i]) begin
        if (m_run[i] != 0 && d == m_exp[i]) begin
          m_run[i]++;
          if (m_run[i] == p_lock) begin
            m_locked[i] = 1;
            m_miss[i] = 0;
          end
        end else begin
          m_run[i] = 1;
        end
        m_exp[i] = (d + 1) & dm;
      end else begin
        if (d != m_exp[i]) begin
          m_pulse[i] = 1;
          inc = 1;
          m_miss[i]++;
        end else begin
          m_miss[i] = 0;
        end
        m_exp[i] = (m_exp[i] + 1) & dm;
        if (m_miss[i] == p_loss) begin
          m_locked[i] = 0;
          m_run[i] = 0;
          m_miss[i] = 0;
        end
      end
    end
    if (c) m_cnt[i] = 0;
    else if (inc) begin
`ifdef PATTERN_CHECKER_SATURATE_EN
      if (m_cnt[i] != cm) m_cnt[i] = m_cnt[i] + 1;
`else
      m_cnt[i] = (m_cnt[i] + 1) & cm;
`endif
    end
  endtask

  task automatic compare_all();
    check_eq("a_locked", locked_a, m_locked[0]);
    check_eq("a_pulse",  pulse_a,  m_pulse[0]);
    check_eq("a_count",  count_a,  m_cnt[0]);
    check_eq("a_expect", exp_a,    m_exp[0]);
    check_eq("b_locked", locked_b, m_locked[1]);
    check_eq("b_pulse",  pulse_b,  m_pulse[1]);
    check_eq("b_count",  count_b,  m_cnt[1]);
    check_eq("b_expect", exp_b,    m_exp[1]);
  endtask

  task automatic step(input bit v, input longint unsigned d, input bit c);
    in_valid = v;
    data_a = d[31:0];
    data_b = d[7:0];
    clear = c;
    @(posedge clk);
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  longint unsigned d;

  initial begin
    nrst = 1'b0; in_valid = 1'b0; clear = 1'b0; data_a = '0; data_b = '0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    nrst = 1'b1;

    // Lock on 5..8
    step(1, 5, 0); step(1, 6, 0); step(1, 7, 0);
    check_eq("lock_early", locked_a, 0);
    step(1, 8, 0);
    check_eq("lock_locked", locked_a, 1);
    check_eq("lock_expect", exp_a, 9);
    check_eq("lock_count", count_a, 0);

    // Wrap on narrow instance
    do_reset();
    step(1, 'hFD, 0); step(1, 'hFE, 0); step(1, 'hFF, 0); step(1, 'h100, 0); step(1, 'h101, 0);
    check_eq("wrap_locked", locked_b, 1);
    check_eq("wrap_pulse", pulse_b, 0);
    check_eq("wrap_expect", exp_b, 2);

    // Single error
    do_reset();
    for (int unsigned k = 10; k <= 14; k++) step(1, k, 0);
    step(1, 99, 0);
    check_eq("single_pulse", pulse_a, 1);
    step(1, 16, 0);
    check_eq("single_pulse_end", pulse_a, 0);
    check_eq("single_count", count_a, 1);
    check_eq("single_locked", locked_a, 1);
    check_eq("single_expect", exp_a, 17);

    // Loss and relock
    do_reset();
    for (int unsigned k = 10; k <= 13; k++) step(1, k, 0);
    step(1, 200, 0); step(1, 300, 0);
    check_eq("loss_still", locked_a, 1);
    step(1, 400, 0);
    check_eq("loss_locked", locked_a, 0);
    check_eq("loss_count", count_a, 3);
    for (int unsigned k = 50; k <= 53; k++) step(1, k, 0);
    check_eq("relock_locked", locked_a, 1);
    check_eq("relock_count", count_a, 3);

    // Gaps, then mismatch with clear
    do_reset();
    for (int unsigned k = 20; k <= 23; k++) begin
      step(1, k, 0);
      step(0, 777, 0);
      step(0, 0, 0);
    end
    check_eq("gap_locked", locked_a, 1);
    step(1, 5, 1);
    check_eq("clear_pulse", pulse_a, 1);
    check_eq("clear_count", count_a, 0);

    // Five isolated mismatches on the narrow counter
    do_reset();
    for (int unsigned k = 0; k <= 3; k++) step(1, k, 0);
    for (int n = 0; n < 5; n++) begin
      step(1, m_exp[0] + 100, 0);
      step(1, m_exp[0], 0);
    end
    check_eq("sat_count_a", count_a, 5);
`ifdef PATTERN_CHECKER_SATURATE_EN
    check_eq("sat_count_b", count_b, 3);
`else
    check_eq("sat_count_b", count_b, 1);
`endif
    check_eq("sat_locked_b", locked_b, 1);

    // Randomised stream: mostly sequential, with corrupted words, gaps, clears and resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 9))
          0:       d = longint'($urandom);
          1:       d = m_exp[0] + longint'($urandom_range(1, 3));
          default: d = m_exp[0];
        endcase
        step($urandom_range(0, 4) != 0, d, $urandom_range(0, 49) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
